// File: rtl/bram_stream_reader_if.sv
// Control, RAM read-port and stream signals of bram_stream_reader.
// The loop input exists only when BRAM_STREAM_READER_LOOP_EN is defined.
interface bram_stream_reader_if #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 32
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH) + 1;

    logic             start;
    logic [AW-1:0]    base_addr;
    logic [LW-1:0]    length;
`ifdef BRAM_STREAM_READER_LOOP_EN
    logic             loop;
`endif
    logic             busy;
    logic             done;
    logic [AW-1:0]    bram_addr;
    logic [WIDTH-1:0] bram_data;
    logic             m_valid;
    logic             m_ready;
    logic [WIDTH-1:0] m_data;
    logic             m_last;

    modport master (
`ifdef BRAM_STREAM_READER_LOOP_EN
        input  loop,
`endif
        input  start, base_addr, length, bram_data, m_ready,
        output busy, done, bram_addr, m_valid, m_data, m_last
    );

    modport slave (
`ifdef BRAM_STREAM_READER_LOOP_EN
        output loop,
`endif
        output start, base_addr, length, bram_data, m_ready,
        input  busy, done, bram_addr, m_valid, m_data, m_last
    );
endinterface

// File: rtl/bram_stream_reader.sv
// Walks an address range of a one-cycle-latency RAM and streams the words out
// through a 2-entry skid FIFO. Optional repeat mode: BRAM_STREAM_READER_LOOP_EN.
module bram_stream_reader #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 32
) (
    input logic                 clk,
    input logic                 rstn,
    bram_stream_reader_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t           state, state_nxt;
    logic [AW-1:0]    rd_ptr_p0;
    logic [LW-1:0]    issue_cnt;
    logic [LW-1:0]    out_cnt;
    logic [LW-1:0]    len_q;
`ifdef BRAM_STREAM_READER_LOOP_EN
    logic [AW-1:0]    base_q;
    logic             loop_q;
`endif
    logic [AW-1:0]    bram_addr_p1;
    logic             vld_p1;
    logic [WIDTH-1:0] fifo_mem [2];
    logic             wr_idx, rd_idx;
    logic [1:0]       fifo_cnt;
    logic             issue, pop, push, more;

    // Address increment that wraps at DEPTH-1, also for non-power-of-two depths.
    function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a);
        if (a == AW'(DEPTH - 1)) return '0;
        return a + AW'(1);
    endfunction

    assign pop   = bus.m_valid & bus.m_ready;
    assign push  = vld_p1;
    assign issue = (state == RUN) && (issue_cnt != '0) &&
                   (((fifo_cnt + 2'(vld_p1)) < 2'd2) || pop);
    // Words still behind the head decide whether an out_cnt==1 pop ends the transfer.
    assign more  = (issue_cnt != '0) || vld_p1 || (fifo_cnt == 2'd2);

    assign bus.bram_addr = bram_addr_p1;
    assign bus.m_valid   = (fifo_cnt != 2'd0);
    assign bus.m_data    = fifo_mem[rd_idx];
    assign bus.m_last    = bus.m_valid && (out_cnt == LW'(1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = (bus.length == '0) ? DONE : RUN;
            RUN:     if (issue_cnt == '0) state_nxt = DRAIN;
            DRAIN:   if (pop && (out_cnt == LW'(1)) && !more) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.busy = (state != IDLE);
        bus.done = (state == DONE);
    end

    // Stage p0 -> p1: address issue and read counters
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_ptr_p0    <= '0;
            issue_cnt    <= '0;
            out_cnt      <= '0;
            len_q        <= '0;
`ifdef BRAM_STREAM_READER_LOOP_EN
            base_q       <= '0;
            loop_q       <= 1'b0;
`endif
            bram_addr_p1 <= '0;
            vld_p1       <= 1'b0;
        end else begin
            vld_p1 <= issue;
            if (state == IDLE && bus.start) begin
                rd_ptr_p0 <= bus.base_addr;
                issue_cnt <= bus.length;
                out_cnt   <= bus.length;
                len_q     <= bus.length;
`ifdef BRAM_STREAM_READER_LOOP_EN
                base_q    <= bus.base_addr;
                loop_q    <= bus.loop;
`endif
            end else begin
                if (issue) begin
                    bram_addr_p1 <= rd_ptr_p0;
`ifdef BRAM_STREAM_READER_LOOP_EN
                    if (issue_cnt == LW'(1) && loop_q && bus.loop) begin
                        issue_cnt <= len_q;
                        rd_ptr_p0 <= base_q;
                    end else begin
                        issue_cnt <= issue_cnt - LW'(1);
                        rd_ptr_p0 <= next_addr(rd_ptr_p0);
                        if (issue_cnt == LW'(1)) loop_q <= 1'b0;
                    end
`else
                    issue_cnt <= issue_cnt - LW'(1);
                    rd_ptr_p0 <= next_addr(rd_ptr_p0);
`endif
                end
                if (pop) begin
                    out_cnt <= (out_cnt == LW'(1) && more) ? len_q : out_cnt - LW'(1);
                end
            end
        end
    end

    // Stage p1 -> p2: capture RAM data into the skid FIFO
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
            wr_idx      <= 1'b0;
            rd_idx      <= 1'b0;
            fifo_cnt    <= 2'd0;
        end else begin
            if (push) begin
                fifo_mem[wr_idx] <= bus.bram_data;
                wr_idx           <= ~wr_idx;
            end
            if (pop) rd_idx <= ~rd_idx;
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
                2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end
endmodule

// File: tb/tb_bram_stream_reader.sv
// Directed bench for bram_stream_reader against a RAM preloaded with 0x1000+i.
// Covers the loop feature as well when BRAM_STREAM_READER_LOOP_EN is defined.
module tb_bram_stream_reader;
    localparam int WIDTH = 16;
    localparam int DEPTH = 32;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    bram_stream_reader_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    bram_stream_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rstn(rstn),
        .bus (bus)
    );

    logic [WIDTH-1:0] mem [DEPTH];
    initial for (int i = 0; i < DEPTH; i++) mem[i] = 16'h1000 + 16'(i);
    assign bus.bram_data = mem[bus.bram_addr];

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] w_data [$];
    bit               w_last [$];
    int               w_cyc  [$];
    int               d_cyc  [$];
    logic [4:0]       a_log  [$];
    logic [4:0]       last_a     = '0;
    bit               prev_stall = 1'b0;
    logic [WIDTH-1:0] prev_data  = '0;
    int               stall_bad  = 0;

    always @(negedge clk) begin
        if (rstn) begin
            if (bus.m_valid && bus.m_ready) begin
                w_data.push_back(bus.m_data);
                w_last.push_back(bus.m_last);
                w_cyc.push_back(cyc);
            end
            if (bus.done) d_cyc.push_back(cyc);
            if (bus.bram_addr != last_a) a_log.push_back(bus.bram_addr);
            if (prev_stall && (!bus.m_valid || bus.m_data !== prev_data))
                stall_bad <= stall_bad + 1;
            last_a     <= bus.bram_addr;
            prev_stall <= bus.m_valid && !bus.m_ready;
            prev_data  <= bus.m_data;
        end else begin
            last_a     <= '0;
            prev_stall <= 1'b0;
        end
    end

    task automatic do_start(input logic [4:0] base, input logic [5:0] len, output int sc);
        @(posedge clk); #1;
        bus.start     = 1'b1;
        bus.base_addr = base;
        bus.length    = len;
        @(posedge clk); #1;
        bus.start = 1'b0;
        sc = cyc;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        @(negedge clk);
        while (bus.busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (bus.busy) begin
            errors++;
            $display("FAIL %s_timeout busy=%0b required 0", tag, bus.busy);
        end
    endtask

    task automatic test_reset();
        @(negedge clk); @(negedge clk);
        checks++; if (bus.busy !== 1'b0)   begin errors++; $display("FAIL rst_busy got %b exp 0", bus.busy); end
        checks++; if (bus.done !== 1'b0)   begin errors++; $display("FAIL rst_done got %b exp 0", bus.done); end
        checks++; if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", bus.m_valid); end
        checks++; if (bus.m_last !== 1'b0) begin errors++; $display("FAIL rst_last got %b exp 0", bus.m_last); end
        checks++; if (bus.m_data !== 16'h0) begin errors++; $display("FAIL rst_data got %h exp 0", bus.m_data); end
        checks++; if (bus.bram_addr !== 5'd0) begin errors++; $display("FAIL rst_addr got %0d exp 0", bus.bram_addr); end
        @(posedge clk); #1;
        rstn = 1'b1;
    endtask

    task automatic test_basic();
        int b  = w_data.size();
        int dn = d_cyc.size();
        int sc;
        bus.m_ready = 1'b1;
        do_start(5'd4, 6'd4, sc);
        wait_idle("basic");
        checks++;
        if (w_data.size() - b != 4) begin errors++; $display("FAIL basic_count got %0d exp 4", w_data.size() - b); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (b + i >= w_data.size()) begin errors++; $display("FAIL basic_word[%0d] got none exp %h", i, 16'h1004 + 16'(i)); end
            else if (w_data[b+i] !== 16'h1004 + 16'(i) || w_last[b+i] !== (i == 3) || w_cyc[b+i] != sc + 2 + i) begin
                errors++;
                $display("FAIL basic_word[%0d] got %h last %0b cyc %0d exp %h last %0b cyc %0d",
                         i, w_data[b+i], w_last[b+i], w_cyc[b+i], 16'h1004 + 16'(i), (i == 3), sc + 2 + i);
            end
        end
        checks++;
        if (d_cyc.size() - dn != 1) begin errors++; $display("FAIL basic_done_count got %0d exp 1", d_cyc.size() - dn); end
        else if (d_cyc[dn] != sc + 6) begin errors++; $display("FAIL basic_done_cyc got %0d exp %0d", d_cyc[dn], sc + 6); end
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL basic_busy_after got %b exp 0", bus.busy); end
    endtask

    task automatic test_stall();
        bit pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        int b  = w_data.size();
        int ab = a_log.size();
        int sb = stall_bad;
        int n  = 0;
        int sc;
        bus.m_ready = 1'b1;
        do_start(5'd4, 6'd4, sc);
        while (bus.busy && n < 200) begin
            bus.m_ready = pat[n % 6];
            @(posedge clk); #1;
            n++;
        end
        bus.m_ready = 1'b1;
        checks++;
        if (bus.busy) begin errors++; $display("FAIL stall_timeout busy=%0b required 0", bus.busy); end
        checks++;
        if (w_data.size() - b != 4) begin errors++; $display("FAIL stall_count got %0d exp 4", w_data.size() - b); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (b + i >= w_data.size()) begin errors++; $display("FAIL stall_word[%0d] got none exp %h", i, 16'h1004 + 16'(i)); end
            else if (w_data[b+i] !== 16'h1004 + 16'(i) || w_last[b+i] !== (i == 3)) begin
                errors++;
                $display("FAIL stall_word[%0d] got %h last %0b exp %h last %0b", i, w_data[b+i], w_last[b+i], 16'h1004 + 16'(i), (i == 3));
            end
        end
        checks++;
        if (stall_bad != sb) begin errors++; $display("FAIL stall_hold got %0d changes exp 0", stall_bad - sb); end
        checks++;
        if (a_log.size() - ab != 4) begin errors++; $display("FAIL stall_addr_count got %0d exp 4", a_log.size() - ab); end
        else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (a_log[ab+i] !== 5'(4 + i)) begin errors++; $display("FAIL stall_addr[%0d] got %0d exp %0d", i, a_log[ab+i], 4 + i); end
            end
        end
    endtask

    task automatic test_len0();
        int b  = w_data.size();
        int dn = d_cyc.size();
        int sc;
        do_start(5'd9, 6'd0, sc);
        @(negedge clk);
        checks++; if (bus.busy !== 1'b1)    begin errors++; $display("FAIL len0_busy1 got %b exp 1", bus.busy); end
        checks++; if (bus.done !== 1'b1)    begin errors++; $display("FAIL len0_done1 got %b exp 1", bus.done); end
        checks++; if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL len0_valid got %b exp 0", bus.m_valid); end
        @(negedge clk);
        checks++; if (bus.busy !== 1'b0)    begin errors++; $display("FAIL len0_busy2 got %b exp 0", bus.busy); end
        checks++; if (bus.done !== 1'b0)    begin errors++; $display("FAIL len0_done2 got %b exp 0", bus.done); end
        checks++; if (w_data.size() != b)   begin errors++; $display("FAIL len0_words got %0d exp 0", w_data.size() - b); end
        checks++; if (d_cyc.size() - dn != 1) begin errors++; $display("FAIL len0_done_count got %0d exp 1", d_cyc.size() - dn); end
    endtask

    task automatic test_wrap();
        logic [WIDTH-1:0] exp [4] = '{16'h101E, 16'h101F, 16'h1000, 16'h1001};
        int b = w_data.size();
        int sc;
        bus.m_ready = 1'b1;
        do_start(5'd30, 6'd4, sc);
        wait_idle("wrap");
        checks++;
        if (w_data.size() - b != 4) begin errors++; $display("FAIL wrap_count got %0d exp 4", w_data.size() - b); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (b + i >= w_data.size()) begin errors++; $display("FAIL wrap_word[%0d] got none exp %h", i, exp[i]); end
            else if (w_data[b+i] !== exp[i] || w_last[b+i] !== (i == 3)) begin
                errors++;
                $display("FAIL wrap_word[%0d] got %h last %0b exp %h last %0b", i, w_data[b+i], w_last[b+i], exp[i], (i == 3));
            end
        end
    endtask

    task automatic test_reset_mid();
        int b, dn, sc;
        bus.m_ready = 1'b0;
        do_start(5'd4, 6'd4, sc);
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (bus.m_valid !== 1'b1 || bus.m_data !== 16'h1004) begin
            errors++; $display("FAIL rmid_pre got valid %b data %h exp valid 1 data 1004", bus.m_valid, bus.m_data);
        end
        rstn = 1'b0;
        #1;
        checks++;
        if ({bus.busy, bus.done, bus.m_valid, bus.m_last} !== 4'b0000 || bus.m_data !== 16'h0 || bus.bram_addr !== 5'd0) begin
            errors++;
            $display("FAIL rmid_async got busy %b done %b valid %b last %b data %h addr %0d exp all 0",
                     bus.busy, bus.done, bus.m_valid, bus.m_last, bus.m_data, bus.bram_addr);
        end
        @(posedge clk); #1;
        rstn = 1'b1;
        b  = w_data.size();
        dn = d_cyc.size();
        bus.m_ready = 1'b1;
        do_start(5'd0, 6'd2, sc);
        wait_idle("rmid");
        checks++;
        if (w_data.size() - b != 2) begin errors++; $display("FAIL rmid_count got %0d exp 2", w_data.size() - b); end
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (b + i >= w_data.size()) begin errors++; $display("FAIL rmid_word[%0d] got none exp %h", i, 16'h1000 + 16'(i)); end
            else if (w_data[b+i] !== 16'h1000 + 16'(i) || w_last[b+i] !== (i == 1)) begin
                errors++;
                $display("FAIL rmid_word[%0d] got %h last %0b exp %h last %0b", i, w_data[b+i], w_last[b+i], 16'h1000 + 16'(i), (i == 1));
            end
        end
        checks++;
        if (d_cyc.size() - dn != 1) begin errors++; $display("FAIL rmid_done_count got %0d exp 1", d_cyc.size() - dn); end
    endtask

    task automatic test_busy_start();
        int b  = w_data.size();
        int dn = d_cyc.size();
        int sc;
        bus.m_ready = 1'b1;
        do_start(5'd4, 6'd4, sc);
        bus.start     = 1'b1;
        bus.base_addr = 5'd0;
        bus.length    = 6'd2;
        @(posedge clk); #1;
        bus.start = 1'b0;
        wait_idle("bstart");
        checks++;
        if (w_data.size() - b != 4) begin errors++; $display("FAIL bstart_count got %0d exp 4", w_data.size() - b); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (b + i >= w_data.size()) begin errors++; $display("FAIL bstart_word[%0d] got none exp %h", i, 16'h1004 + 16'(i)); end
            else if (w_data[b+i] !== 16'h1004 + 16'(i)) begin
                errors++; $display("FAIL bstart_word[%0d] got %h exp %h", i, w_data[b+i], 16'h1004 + 16'(i));
            end
        end
        checks++;
        if (d_cyc.size() - dn != 1) begin errors++; $display("FAIL bstart_done_count got %0d exp 1", d_cyc.size() - dn); end
        else if (d_cyc[dn] != sc + 6) begin errors++; $display("FAIL bstart_done_cyc got %0d exp %0d", d_cyc[dn], sc + 6); end
    endtask

`ifdef BRAM_STREAM_READER_LOOP_EN
    task automatic test_loop();
        int b  = w_data.size();
        int dn = d_cyc.size();
        int n  = 0;
        int sc, got;
        bus.m_ready = 1'b1;
        bus.loop    = 1'b1;
        do_start(5'd4, 6'd3, sc);
        while (w_data.size() < b + 9 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (w_data.size() < b + 9) begin errors++; $display("FAIL loop_count got %0d exp >=9", w_data.size() - b); end
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (b + i >= w_data.size()) begin errors++; $display("FAIL loop_word[%0d] got none exp %h", i, 16'h1004 + 16'(i % 3)); end
            else if (w_data[b+i] !== 16'h1004 + 16'(i % 3) || w_last[b+i] !== (i % 3 == 2)) begin
                errors++;
                $display("FAIL loop_word[%0d] got %h last %0b exp %h last %0b", i, w_data[b+i], w_last[b+i], 16'h1004 + 16'(i % 3), (i % 3 == 2));
            end
        end
        checks++;
        if (d_cyc.size() != dn) begin errors++; $display("FAIL loop_nodone got %0d pulses exp 0", d_cyc.size() - dn); end
        @(posedge clk); #1;
        bus.loop = 1'b0;
        wait_idle("loop_end");
        got = w_data.size() - b;
        checks++;
        if (got % 3 != 0 || w_data[w_data.size()-1] !== 16'h1006 || w_last[w_last.size()-1] !== 1'b1) begin
            errors++; $display("FAIL loop_end got %0d words tail %h exp multiple of 3 tail 1006", got, w_data[w_data.size()-1]);
        end
        checks++;
        if (d_cyc.size() - dn != 1) begin errors++; $display("FAIL loop_done_count got %0d exp 1", d_cyc.size() - dn); end
    endtask
`endif

    initial begin
        bus.start     = 1'b0;
        bus.base_addr = '0;
        bus.length    = '0;
        bus.m_ready   = 1'b0;
`ifdef BRAM_STREAM_READER_LOOP_EN
        bus.loop      = 1'b0;
`endif
        test_reset();
        test_basic();
        test_stall();
        test_len0();
        test_wrap();
        test_reset_mid();
        test_busy_start();
`ifdef BRAM_STREAM_READER_LOOP_EN
        test_loop();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached, required completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/bram_stream_reader.md
Name: bram_stream_reader

Overview:
- Read-side master for the single-clock use of the dual-port block RAM.
- Walks a contiguous address range and drives the RAM read address.
- Absorbs the RAM's fixed one-cycle read latency and emits the words as a valid/ready stream with a last flag.
- Sits between a frame/vertex buffer RAM and downstream consumers such as the rasterizer or scanout.

Parameters:
WIDTH, 16, data word width; must match the RAM WIDTH.
DEPTH, 32, RAM depth in words; address width AW = $clog2(DEPTH), length width LW = $clog2(DEPTH)+1.

Ports:
clk  input  1  single clock for the RAM read port and this block.
rstn  input  1  asynchronous active-low reset.
start  input  1  one-cycle request; sampled only in IDLE.
base_addr  input  AW  first word address, captured on start.
length  input  LW  number of words, 0..DEPTH, captured on start.
busy  output  1  high from accepted start until done.
done  output  1  one-cycle pulse after the last word is handshaken.
bram_addr  output  AW  to the RAM read address; registered.
bram_data  input  WIDTH  RAM read data; valid one cycle after bram_addr.
m_valid  output  1  stream valid.
m_ready  input  1  stream ready.
m_data  output  WIDTH  stream data.
m_last  output  1  high with the final word of a transfer.

Behaviour:
- Reset (rstn low, asynchronous): state IDLE.
  - busy=0, done=0, m_valid=0, m_last=0, m_data=0, bram_addr=0.
  - Skid buffer and in-flight flag are cleared.
  - Reset mid-transfer aborts with no done pulse and no further words.
- States:
  - IDLE: start=1 with length>0 → RUN; rd_ptr=base_addr, issue_cnt=length, out_cnt=length.
  - IDLE: start=1 with length=0 → DONE.
  - RUN: stays until issue_cnt=0 → DRAIN.
  - DRAIN: stays until the last word handshakes → DONE.
  - DONE: done=1 for exactly one cycle, → IDLE.
  - busy = (state != IDLE).
- start while busy is ignored and has no side effect.
- Read issue: in RUN, a read issues in a cycle when issue_cnt>0 and (fifo_cnt + inflight < 2, or a stream pop occurs in the same cycle).
  - On issue: bram_addr <= rd_ptr, inflight <= 1, issue_cnt decrements, rd_ptr advances.
  - rd_ptr wraps DEPTH-1 → 0; this applies to non-power-of-two DEPTH as well.
- Capture: the cycle after an issue, bram_data is written into a 2-entry FIFO (skid buffer).
  - The FIFO never overflows because of the credit rule above.
- Stream output:
  - m_valid = (fifo_cnt>0), with m_data = FIFO head.
  - Pop on m_valid & m_ready; out_cnt decrements on each pop.
  - m_last = m_valid & (out_cnt==1).
  - m_data holds and is stable while m_valid=1 and m_ready=0.
- Simultaneous push and pop leaves fifo_cnt unchanged, order preserved.
- Latency: start accepted at edge N → first address at edge N+1 → data captured at edge N+2 → m_valid high after edge N+2.
- Throughput: with m_ready held at 1, one word per cycle; an L-word transfer ends with done high in the cycle after the last handshake.
- Words are delivered in address order with no loss or duplication under any m_ready pattern.

Optional Feature:
- Macro: BRAM_STREAM_READER_LOOP_EN.
- With the macro: adds input `loop` (1 bit), sampled on start.
  - If loop=1, after the last issue rd_ptr reloads base_addr and issue_cnt reloads length without a bubble.
  - m_last still marks every length-th word.
  - done never pulses; the transfer ends only on reset or when loop is sampled 0 at a wrap point, which then finishes normally with done.
- Without the macro: no `loop` port; every transfer is single-shot.

Test Plan:
- RAM preloaded 0x1000+i; start, base=4, length=4, m_ready=1 → m_data 0x1004..0x1007 on consecutive cycles, m_last on 0x1007, done one cycle later, busy low after.
- base=4, length=4, m_ready toggling 1,0,0,1,0,1… → same four words in order, m_data stable during stalls, no extra reads (bram_addr sequence 4,5,6,7 only).
- length=0 → no m_valid, done pulses on the second cycle after start, busy high exactly one cycle.
- DEPTH=32, base=30, length=4 → words at addresses 30,31,0,1; m_last on the word from address 1.
- Reset asserted mid-transfer after 2 words, with m_ready=0 → all outputs 0 immediately; a new start (base=0, length=2) afterwards yields words 0x1000 and 0x1001 only.
- start pulsed again while busy with base=0 → ignored, original sequence unchanged. With BRAM_STREAM_READER_LOOP_EN and loop=1, length=3 → 0x1004,0x1005,0x1006 repeating, m_last every third word, no done.
